// File: rtl/axi_id_remap_pkg.sv
// Shared definitions for the AXI ID remapper.
// Holds the counter-width helper, the user-width helper and the
// parameter-independent lookup-result types used by every remap table.
package axi_id_remap_pkg;

    // Counter width needed to hold 0..max_txns outstanding transactions.
    function automatic int unsigned cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

    // A zero-width user field is carried as a single unused bit.
    function automatic int unsigned user_width(input int unsigned w);
        return (w > 0) ? w : 1;
    endfunction

    // How a request was matched to a slot.
    typedef enum logic [1:0] {
        LKP_NONE  = 2'd0,
        LKP_MATCH = 2'd1,
        LKP_FREE  = 2'd2
    } lkp_kind_e;

    // Lookup flags: hit = valid entry with this ID exists, hit_full = that
    // entry is at its limit, free = some invalid entry exists, avail = a slot
    // can take the request this cycle.
    typedef struct packed {
        logic hit;
        logic hit_full;
        logic free;
        logic avail;
    } lkp_flags_t;

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle with Master/Slave views.
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH
// (a user width of 0 is carried as one bit).
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 0
);
    localparam int unsigned USER_W = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [USER_W-1:0]         aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic                      w_last;
    logic [USER_W-1:0]         w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [USER_W-1:0]         b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [USER_W-1:0]         ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [USER_W-1:0]         r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_id_remap_table.sv
// One ID remap table (used once for writes, once for reads).
// Ports: clk_i/rst_ni clock and async active-low reset; req_id/req_fire the
// incoming request ID and its handshake; req_avail/req_slot whether and where
// it can go; rsp_slot/rsp_fire the narrow response ID and a releasing
// handshake; rsp_id the original wide ID stored for rsp_slot.
// Optional checks are compiled in with AXI_ID_REMAP_ASSERT_EN.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned ID_IN_WIDTH  = 12,
    parameter int unsigned ID_OUT_WIDTH = 2,
    parameter int unsigned MAX_TXNS     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ID_IN_WIDTH-1:0]  req_id,
    input  logic                    req_fire,
    output logic                    req_avail,
    output logic [ID_OUT_WIDTH-1:0] req_slot,
    input  logic [ID_OUT_WIDTH-1:0] rsp_slot,
    input  logic                    rsp_fire,
    output logic [ID_IN_WIDTH-1:0]  rsp_id
);
    localparam int unsigned N  = 2 ** ID_OUT_WIDTH;
    localparam int unsigned CW = cnt_width(MAX_TXNS);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_TXNS);

    logic [N-1:0]                  valid_r;
    logic [N-1:0][ID_IN_WIDTH-1:0] orig_id_r;
    logic [N-1:0][CW-1:0]          cnt_r;

    logic [N-1:0]                  valid_nxt_s;
    logic [N-1:0][ID_IN_WIDTH-1:0] orig_id_nxt_s;
    logic [N-1:0][CW-1:0]          cnt_nxt_s;
    logic [N-1:0]                  inc_s;
    logic [N-1:0]                  dec_s;

    lkp_flags_t              flags_s;
    lkp_kind_e               kind_s;
    logic [ID_OUT_WIDTH-1:0] hit_idx_s;
    logic [ID_OUT_WIDTH-1:0] free_idx_s;

    // Slot lookup from registered state only, so a slot freed this cycle is not reused until the next one.
    always_comb begin
        flags_s    = '0;
        hit_idx_s  = '0;
        free_idx_s = '0;
        // Descending scan: the last assignment wins, giving the lowest free index.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                flags_s.free = 1'b1;
                free_idx_s   = ID_OUT_WIDTH'(i);
            end else if (orig_id_r[i] == req_id) begin
                flags_s.hit = 1'b1;
                hit_idx_s   = ID_OUT_WIDTH'(i);
            end else begin
                flags_s.hit = flags_s.hit;
            end
        end
        flags_s.hit_full = flags_s.hit && (cnt_r[hit_idx_s] >= CNT_MAX);
        // An ID already holding a slot never takes a second one: ordering per ID is kept.
        if (flags_s.hit) begin
            kind_s = flags_s.hit_full ? LKP_NONE : LKP_MATCH;
        end else if (flags_s.free) begin
            kind_s = LKP_FREE;
        end else begin
            kind_s = LKP_NONE;
        end
        flags_s.avail = (kind_s != LKP_NONE);
        case (kind_s)
            LKP_MATCH: req_slot = hit_idx_s;
            LKP_FREE:  req_slot = free_idx_s;
            default:   req_slot = '0;
        endcase
        req_avail = flags_s.avail;
    end

    assign rsp_id = orig_id_r[rsp_slot];

    // Per-entry allocate/release bookkeeping; an entry whose count reaches zero is invalid next cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inc_s[i] = req_fire && (req_slot == ID_OUT_WIDTH'(i));
            dec_s[i] = rsp_fire && (rsp_slot == ID_OUT_WIDTH'(i)) && (cnt_r[i] != '0);
            if (inc_s[i] && !dec_s[i]) begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end else if (dec_s[i] && !inc_s[i]) begin
                cnt_nxt_s[i] = cnt_r[i] - CW'(1);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            if (inc_s[i]) begin
                orig_id_nxt_s[i] = req_id;
            end else begin
                orig_id_nxt_s[i] = orig_id_r[i];
            end
            valid_nxt_s[i] = (cnt_nxt_s[i] != '0);
        end
    end

    // Table state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r   <= '0;
            orig_id_r <= '0;
            cnt_r     <= '0;
        end else begin
            valid_r   <= valid_nxt_s;
            orig_id_r <= orig_id_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

`ifdef AXI_ID_REMAP_ASSERT_EN
    logic [N-1:0] ovf_s;

    // Flags an entry asked to count past its limit.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ovf_s[i] = inc_s[i] && !dec_s[i] && (cnt_r[i] >= CNT_MAX);
        end
    end

    axi_id_remap_table_sva u_sva (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rsp_fire        (rsp_fire),
        .rsp_entry_valid (valid_r[rsp_slot]),
        .cnt_overflow    (|ovf_s)
    );
`else
    // Checks not elaborated in this build.
`endif

endmodule

`ifdef AXI_ID_REMAP_ASSERT_EN
// Table consistency checks: responses must address a live entry, counts must not overflow.
module axi_id_remap_table_sva (
    input logic clk_i,
    input logic rst_ni,
    input logic rsp_fire,
    input logic rsp_entry_valid,
    input logic cnt_overflow
);
    a_rsp_valid_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_fire |-> rsp_entry_valid);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !cnt_overflow);
endmodule
`else
`endif

// File: rtl/axi_id_remap.sv
// AXI ID remapper: narrows wide crossbar IDs onto 2**AXI_ID_OUT_WIDTH slots.
// Ports: clk_i clock, rst_ni async active-low reset, in (AXI_BUS.Slave, wide
// IDs), out (AXI_BUS.Master, narrow IDs). All paths are combinational; only
// the write and read remap tables hold state.
// Macro AXI_ID_REMAP_ASSERT_EN adds protocol/bookkeeping checks.
module axi_id_remap
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 32,
    parameter int unsigned AXI_USER_WIDTH   = 0,
    parameter int unsigned AXI_ID_IN_WIDTH  = 12,
    parameter int unsigned AXI_ID_OUT_WIDTH = 2,
    parameter int unsigned MAX_TXNS_PER_ID  = 4
) (
    input logic    clk_i,
    input logic    rst_ni,
    AXI_BUS.Slave  in,
    AXI_BUS.Master out
);
    localparam int unsigned USER_W = user_width(AXI_USER_WIDTH);

    logic                        wr_avail_s;
    logic [AXI_ID_OUT_WIDTH-1:0] wr_slot_s;
    logic [AXI_ID_IN_WIDTH-1:0]  wr_rsp_id_s;
    logic                        rd_avail_s;
    logic [AXI_ID_OUT_WIDTH-1:0] rd_slot_s;
    logic [AXI_ID_IN_WIDTH-1:0]  rd_rsp_id_s;
    logic                        aw_fire_s;
    logic                        ar_fire_s;
    logic                        b_fire_s;
    logic                        r_last_fire_s;

    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_s;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr_s;
    logic [AXI_DATA_WIDTH-1:0]   w_data_s;
    logic [AXI_DATA_WIDTH-1:0]   r_data_s;
    logic [USER_W-1:0]           aw_user_s;
    logic [USER_W-1:0]           ar_user_s;

    // AW: gated by write-slot availability, ID replaced by the slot index.
    assign aw_fire_s     = in.aw_valid && out.aw_ready && wr_avail_s;
    assign out.aw_valid  = in.aw_valid && wr_avail_s;
    assign in.aw_ready   = out.aw_ready && wr_avail_s;
    assign out.aw_id     = wr_slot_s;
    assign aw_addr_s     = in.aw_addr;
    assign out.aw_addr   = aw_addr_s;
    assign out.aw_len    = in.aw_len;
    assign out.aw_size   = in.aw_size;
    assign out.aw_burst  = in.aw_burst;
    assign out.aw_lock   = in.aw_lock;
    assign out.aw_cache  = in.aw_cache;
    assign out.aw_prot   = in.aw_prot;
    assign out.aw_qos    = in.aw_qos;
    assign out.aw_region = in.aw_region;
    assign aw_user_s     = in.aw_user;
    assign out.aw_user   = aw_user_s;

    // W: untouched in both directions.
    assign w_data_s      = in.w_data;
    assign out.w_data    = w_data_s;
    assign out.w_strb    = in.w_strb;
    assign out.w_last    = in.w_last;
    assign out.w_user    = in.w_user;
    assign out.w_valid   = in.w_valid;
    assign in.w_ready    = out.w_ready;

    // B: restores the original ID; never depends on AW.
    assign b_fire_s      = out.b_valid && in.b_ready;
    assign in.b_id       = wr_rsp_id_s;
    assign in.b_resp     = out.b_resp;
    assign in.b_user     = out.b_user;
    assign in.b_valid    = out.b_valid;
    assign out.b_ready   = in.b_ready;

    // AR: same scheme as AW against the read table.
    assign ar_fire_s     = in.ar_valid && out.ar_ready && rd_avail_s;
    assign out.ar_valid  = in.ar_valid && rd_avail_s;
    assign in.ar_ready   = out.ar_ready && rd_avail_s;
    assign out.ar_id     = rd_slot_s;
    assign ar_addr_s     = in.ar_addr;
    assign out.ar_addr   = ar_addr_s;
    assign out.ar_len    = in.ar_len;
    assign out.ar_size   = in.ar_size;
    assign out.ar_burst  = in.ar_burst;
    assign out.ar_lock   = in.ar_lock;
    assign out.ar_cache  = in.ar_cache;
    assign out.ar_prot   = in.ar_prot;
    assign out.ar_qos    = in.ar_qos;
    assign out.ar_region = in.ar_region;
    assign ar_user_s     = in.ar_user;
    assign out.ar_user   = ar_user_s;

    // R: only the last beat of a burst releases the read entry.
    assign r_last_fire_s = out.r_valid && in.r_ready && out.r_last;
    assign in.r_id       = rd_rsp_id_s;
    assign r_data_s      = out.r_data;
    assign in.r_data     = r_data_s;
    assign in.r_resp     = out.r_resp;
    assign in.r_last     = out.r_last;
    assign in.r_user     = out.r_user;
    assign in.r_valid    = out.r_valid;
    assign out.r_ready   = in.r_ready;

    axi_id_remap_table #(
        .ID_IN_WIDTH  (AXI_ID_IN_WIDTH),
        .ID_OUT_WIDTH (AXI_ID_OUT_WIDTH),
        .MAX_TXNS     (MAX_TXNS_PER_ID)
    ) u_wr_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_id    (in.aw_id),
        .req_fire  (aw_fire_s),
        .req_avail (wr_avail_s),
        .req_slot  (wr_slot_s),
        .rsp_slot  (out.b_id),
        .rsp_fire  (b_fire_s),
        .rsp_id    (wr_rsp_id_s)
    );

    axi_id_remap_table #(
        .ID_IN_WIDTH  (AXI_ID_IN_WIDTH),
        .ID_OUT_WIDTH (AXI_ID_OUT_WIDTH),
        .MAX_TXNS     (MAX_TXNS_PER_ID)
    ) u_rd_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_id    (in.ar_id),
        .req_fire  (ar_fire_s),
        .req_avail (rd_avail_s),
        .req_slot  (rd_slot_s),
        .rsp_slot  (out.r_id),
        .rsp_fire  (r_last_fire_s),
        .rsp_id    (rd_rsp_id_s)
    );

`ifdef AXI_ID_REMAP_ASSERT_EN
    localparam int unsigned REQ_PW = AXI_ID_IN_WIDTH + AXI_ADDR_WIDTH + 29 + USER_W;

    logic [REQ_PW-1:0] aw_payload_s;
    logic [REQ_PW-1:0] ar_payload_s;

    assign aw_payload_s = {in.aw_id, in.aw_addr, in.aw_len, in.aw_size, in.aw_burst, in.aw_lock,
                           in.aw_cache, in.aw_prot, in.aw_qos, in.aw_region, in.aw_user};
    assign ar_payload_s = {in.ar_id, in.ar_addr, in.ar_len, in.ar_size, in.ar_burst, in.ar_lock,
                           in.ar_cache, in.ar_prot, in.ar_qos, in.ar_region, in.ar_user};

    axi_id_remap_sva #(.PW(REQ_PW)) u_sva (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .aw_valid   (in.aw_valid),
        .aw_ready   (in.aw_ready),
        .aw_payload (aw_payload_s),
        .ar_valid   (in.ar_valid),
        .ar_ready   (in.ar_ready),
        .ar_payload (ar_payload_s)
    );
`else
    // Checks not elaborated in this build.
`endif

endmodule

`ifdef AXI_ID_REMAP_ASSERT_EN
// Request payload must hold while a request is stalled.
module axi_id_remap_sva #(
    parameter int unsigned PW = 8
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          aw_valid,
    input logic          aw_ready,
    input logic [PW-1:0] aw_payload,
    input logic          ar_valid,
    input logic          ar_ready,
    input logic [PW-1:0] ar_payload
);
    a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (aw_valid && !aw_ready) |=> $stable(aw_payload));
    a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ar_valid && !ar_ready) |=> $stable(ar_payload));
endmodule
`else
`endif

// File: tb/tb_axi_id_remap.sv
module tb_axi_id_remap;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(12), .AXI_USER_WIDTH(0)) in_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(2),  .AXI_USER_WIDTH(0)) out_bus ();

    axi_id_remap #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_USER_WIDTH(0),
        .AXI_ID_IN_WIDTH(12), .AXI_ID_OUT_WIDTH(2), .MAX_TXNS_PER_ID(4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in     (in_bus),
        .out    (out_bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_bus.aw_valid = 1'b0; in_bus.aw_id = 12'h000; in_bus.aw_addr = 32'h0;
        in_bus.aw_len = 8'd0; in_bus.aw_size = 3'd2; in_bus.aw_burst = 2'b01; in_bus.aw_lock = 1'b0;
        in_bus.aw_cache = 4'd0; in_bus.aw_prot = 3'd0; in_bus.aw_qos = 4'd0; in_bus.aw_region = 4'd0;
        in_bus.aw_user = 1'b0;
        in_bus.w_valid = 1'b0; in_bus.w_data = 32'h0; in_bus.w_strb = 4'hF; in_bus.w_last = 1'b0;
        in_bus.w_user = 1'b0; in_bus.b_ready = 1'b1;
        in_bus.ar_valid = 1'b0; in_bus.ar_id = 12'h000; in_bus.ar_addr = 32'h0;
        in_bus.ar_len = 8'd0; in_bus.ar_size = 3'd2; in_bus.ar_burst = 2'b01; in_bus.ar_lock = 1'b0;
        in_bus.ar_cache = 4'd0; in_bus.ar_prot = 3'd0; in_bus.ar_qos = 4'd0; in_bus.ar_region = 4'd0;
        in_bus.ar_user = 1'b0; in_bus.r_ready = 1'b1;
        out_bus.aw_ready = 1'b1; out_bus.w_ready = 1'b1; out_bus.ar_ready = 1'b1;
        out_bus.b_valid = 1'b0; out_bus.b_id = 2'd0; out_bus.b_resp = 2'b00; out_bus.b_user = 1'b0;
        out_bus.r_valid = 1'b0; out_bus.r_id = 2'd0; out_bus.r_data = 32'h0; out_bus.r_resp = 2'b00;
        out_bus.r_last = 1'b0; out_bus.r_user = 1'b0;
    endtask

    // Send one accepted AW (no checking).
    task automatic aw_fire(input logic [11:0] id);
        in_bus.aw_valid = 1'b1; in_bus.aw_id = id;
        tick();
        in_bus.aw_valid = 1'b0;
    endtask

    // Return one B on a narrow slot (no checking).
    task automatic b_release(input logic [1:0] slot);
        out_bus.b_valid = 1'b1; out_bus.b_id = slot;
        tick();
        out_bus.b_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h155;
        #1;
        checks++; if (out_bus.aw_valid !== 1'b1) begin errors++; $display("FAIL rst_aw_valid got %0h exp 1", out_bus.aw_valid); end
        checks++; if (out_bus.aw_id !== 2'd0) begin errors++; $display("FAIL rst_aw_id got %0h exp 0", out_bus.aw_id); end
        in_bus.aw_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        #1;
        checks++; if (out_bus.aw_valid !== 1'b0) begin errors++; $display("FAIL rel_aw_valid got %0h exp 0", out_bus.aw_valid); end
        checks++; if (out_bus.ar_valid !== 1'b0) begin errors++; $display("FAIL rel_ar_valid got %0h exp 0", out_bus.ar_valid); end
        checks++; if (in_bus.aw_ready !== 1'b1) begin errors++; $display("FAIL rel_aw_ready got %0h exp 1", in_bus.aw_ready); end
        in_bus.ar_valid = 1'b1; in_bus.ar_id = 12'h0AA; out_bus.ar_ready = 1'b0;
        #1;
        checks++; if (out_bus.ar_valid !== 1'b1) begin errors++; $display("FAIL rel_ar_follow got %0h exp 1", out_bus.ar_valid); end
        checks++; if (in_bus.ar_ready !== 1'b0) begin errors++; $display("FAIL rel_ar_ready got %0h exp 0", in_bus.ar_ready); end
        in_bus.ar_valid = 1'b0; out_bus.ar_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h155; in_bus.aw_addr = 32'h1000_0040; in_bus.aw_len = 8'd3;
        #1;
        checks++; if (out_bus.aw_valid !== 1'b1) begin errors++; $display("FAIL basic_aw_valid got %0h exp 1", out_bus.aw_valid); end
        checks++; if (out_bus.aw_id !== 2'd0) begin errors++; $display("FAIL basic_aw_id got %0h exp 0", out_bus.aw_id); end
        checks++; if (out_bus.aw_addr !== 32'h1000_0040) begin errors++; $display("FAIL basic_aw_addr got %0h exp 10000040", out_bus.aw_addr); end
        checks++; if (out_bus.aw_len !== 8'd3) begin errors++; $display("FAIL basic_aw_len got %0h exp 3", out_bus.aw_len); end
        tick();
        in_bus.aw_valid = 1'b0;
        out_bus.b_valid = 1'b1; out_bus.b_id = 2'd0; out_bus.b_resp = 2'b10;
        #1;
        checks++; if (in_bus.b_id !== 12'h155) begin errors++; $display("FAIL basic_b_id got %0h exp 155", in_bus.b_id); end
        checks++; if (in_bus.b_resp !== 2'b10) begin errors++; $display("FAIL basic_b_resp got %0h exp 2", in_bus.b_resp); end
        checks++; if (in_bus.b_valid !== 1'b1) begin errors++; $display("FAIL basic_b_valid got %0h exp 1", in_bus.b_valid); end
        tick();
        out_bus.b_valid = 1'b0; out_bus.b_resp = 2'b00;
        // Slot 0 should now be free: a new ID lands on slot 0.
        in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h2AA; out_bus.aw_ready = 1'b0;
        #1;
        checks++; if (out_bus.aw_id !== 2'd0) begin errors++; $display("FAIL basic_freed got %0h exp 0", out_bus.aw_id); end
        checks++; if (in_bus.aw_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_follow got %0h exp 0", in_bus.aw_ready); end
        in_bus.aw_valid = 1'b0; out_bus.aw_ready = 1'b1;
        tick();
    endtask

    task automatic test_max_outstanding();
        for (int k = 0; k < 4; k++) begin
            in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h155;
            #1;
            checks++; if (in_bus.aw_ready !== 1'b1 || out_bus.aw_id !== 2'd0) begin errors++; $display("FAIL max_accept%0d got rdy=%0h id=%0h exp rdy=1 id=0", k, in_bus.aw_ready, out_bus.aw_id); end
            tick();
        end
        #1;
        checks++; if (in_bus.aw_ready !== 1'b0) begin errors++; $display("FAIL max_stall got %0h exp 0", in_bus.aw_ready); end
        checks++; if (out_bus.aw_valid !== 1'b0) begin errors++; $display("FAIL max_stall_valid got %0h exp 0", out_bus.aw_valid); end
        tick();
        out_bus.b_valid = 1'b1; out_bus.b_id = 2'd0;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b0) begin errors++; $display("FAIL max_same_cycle got %0h exp 0", in_bus.aw_ready); end
        checks++; if (in_bus.b_id !== 12'h155) begin errors++; $display("FAIL max_b_id got %0h exp 155", in_bus.b_id); end
        tick();
        out_bus.b_valid = 1'b0;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b1 || out_bus.aw_id !== 2'd0) begin errors++; $display("FAIL max_resume got rdy=%0h id=%0h exp rdy=1 id=0", in_bus.aw_ready, out_bus.aw_id); end
        tick();
        in_bus.aw_valid = 1'b0;
        repeat (4) b_release(2'd0);
    endtask

    task automatic test_slots_full();
        for (int k = 0; k < 4; k++) begin
            in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'(k + 1);
            #1;
            checks++; if (out_bus.aw_id !== 2'(k)) begin errors++; $display("FAIL full_slot%0d got %0h exp %0h", k, out_bus.aw_id, k); end
            tick();
        end
        in_bus.aw_id = 12'h005;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %0h exp 0", in_bus.aw_ready); end
        tick();
        out_bus.b_valid = 1'b1; out_bus.b_id = 2'd2;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b0) begin errors++; $display("FAIL full_no_reuse got %0h exp 0", in_bus.aw_ready); end
        checks++; if (in_bus.b_id !== 12'h003) begin errors++; $display("FAIL full_b_id got %0h exp 3", in_bus.b_id); end
        tick();
        out_bus.b_valid = 1'b0;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b1 || out_bus.aw_id !== 2'd2) begin errors++; $display("FAIL full_reuse got rdy=%0h id=%0h exp rdy=1 id=2", in_bus.aw_ready, out_bus.aw_id); end
        tick();
        in_bus.aw_valid = 1'b0;
        out_bus.b_valid = 1'b1; out_bus.b_id = 2'd2;
        #1;
        checks++; if (in_bus.b_id !== 12'h005) begin errors++; $display("FAIL full_new_b_id got %0h exp 5", in_bus.b_id); end
        tick();
        out_bus.b_valid = 1'b0;
        b_release(2'd0); b_release(2'd1); b_release(2'd3);
    endtask

    task automatic test_read_burst();
        in_bus.ar_valid = 1'b1; in_bus.ar_id = 12'h0AA; in_bus.ar_len = 8'd3;
        #1;
        checks++; if (out_bus.ar_valid !== 1'b1 || out_bus.ar_id !== 2'd0) begin errors++; $display("FAIL rd_ar got v=%0h id=%0h exp v=1 id=0", out_bus.ar_valid, out_bus.ar_id); end
        tick();
        in_bus.ar_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            out_bus.r_valid = 1'b1; out_bus.r_id = 2'd0; out_bus.r_data = 32'hA0 + 32'(k); out_bus.r_last = (k == 3);
            #1;
            checks++; if (in_bus.r_id !== 12'h0AA) begin errors++; $display("FAIL rd_r_id%0d got %0h exp 0aa", k, in_bus.r_id); end
            checks++; if (in_bus.r_data !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL rd_r_data%0d got %0h exp %0h", k, in_bus.r_data, 32'hA0 + 32'(k)); end
            tick();
            out_bus.r_valid = 1'b0; out_bus.r_last = 1'b0;
            if (k == 2) begin
                // Entry still held after non-last beats.
                in_bus.ar_valid = 1'b1; in_bus.ar_id = 12'h0BB; out_bus.ar_ready = 1'b0;
                #1;
                checks++; if (out_bus.ar_id !== 2'd1) begin errors++; $display("FAIL rd_held got %0h exp 1", out_bus.ar_id); end
                in_bus.ar_id = 12'h0AA;
                #1;
                checks++; if (out_bus.ar_valid !== 1'b1 || out_bus.ar_id !== 2'd0) begin errors++; $display("FAIL rd_same_id got v=%0h id=%0h exp v=1 id=0", out_bus.ar_valid, out_bus.ar_id); end
                in_bus.ar_valid = 1'b0; out_bus.ar_ready = 1'b1;
            end
        end
        in_bus.ar_valid = 1'b1; in_bus.ar_id = 12'h0BB; out_bus.ar_ready = 1'b0;
        #1;
        checks++; if (out_bus.ar_id !== 2'd0) begin errors++; $display("FAIL rd_freed got %0h exp 0", out_bus.ar_id); end
        in_bus.ar_valid = 1'b0; out_bus.ar_ready = 1'b1;
        tick();
    endtask

    task automatic test_read_with_write_full();
        aw_fire(12'h010); aw_fire(12'h011); aw_fire(12'h012); aw_fire(12'h013);
        in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h014;
        in_bus.ar_valid = 1'b1; in_bus.ar_id = 12'h007;
        in_bus.w_valid = 1'b1; in_bus.w_data = 32'hDEAD_BEEF; in_bus.w_last = 1'b1;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b0) begin errors++; $display("FAIL mix_aw_stall got %0h exp 0", in_bus.aw_ready); end
        checks++; if (out_bus.ar_valid !== 1'b1 || out_bus.ar_id !== 2'd0 || in_bus.ar_ready !== 1'b1) begin errors++; $display("FAIL mix_ar got v=%0h id=%0h r=%0h exp 1 0 1", out_bus.ar_valid, out_bus.ar_id, in_bus.ar_ready); end
        checks++; if (out_bus.w_valid !== 1'b1 || out_bus.w_data !== 32'hDEAD_BEEF || out_bus.w_last !== 1'b1 || in_bus.w_ready !== 1'b1) begin errors++; $display("FAIL mix_w got v=%0h d=%0h l=%0h r=%0h exp 1 deadbeef 1 1", out_bus.w_valid, out_bus.w_data, out_bus.w_last, in_bus.w_ready); end
        tick();
        in_bus.ar_valid = 1'b0; in_bus.w_valid = 1'b0; in_bus.w_last = 1'b0;
        out_bus.b_valid = 1'b1; out_bus.b_id = 2'd1;
        #1;
        checks++; if (in_bus.b_valid !== 1'b1 || in_bus.b_id !== 12'h011) begin errors++; $display("FAIL mix_b got v=%0h id=%0h exp 1 011", in_bus.b_valid, in_bus.b_id); end
        tick();
        out_bus.b_valid = 1'b0;
        #1;
        checks++; if (in_bus.aw_ready !== 1'b1 || out_bus.aw_id !== 2'd1) begin errors++; $display("FAIL mix_aw_resume got rdy=%0h id=%0h exp 1 1", in_bus.aw_ready, out_bus.aw_id); end
        tick();
        in_bus.aw_valid = 1'b0;
        out_bus.r_valid = 1'b1; out_bus.r_id = 2'd0; out_bus.r_last = 1'b1;
        #1;
        checks++; if (in_bus.r_id !== 12'h007) begin errors++; $display("FAIL mix_r_id got %0h exp 007", in_bus.r_id); end
        tick();
        out_bus.r_valid = 1'b0; out_bus.r_last = 1'b0;
        b_release(2'd0); b_release(2'd1); b_release(2'd2); b_release(2'd3);
    endtask

    task automatic test_reset_mid();
        aw_fire(12'h020); aw_fire(12'h021); aw_fire(12'h022);
        #2 rst_ni = 1'b0;
        #1;
        in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h021; out_bus.aw_ready = 1'b0;
        #1;
        checks++; if (out_bus.aw_id !== 2'd0 || out_bus.aw_valid !== 1'b1) begin errors++; $display("FAIL mid_cleared got id=%0h v=%0h exp 0 1", out_bus.aw_id, out_bus.aw_valid); end
        in_bus.aw_valid = 1'b0; out_bus.aw_ready = 1'b1;
        #1 rst_ni = 1'b1;
        tick();
        in_bus.aw_valid = 1'b1; in_bus.aw_id = 12'h3FF;
        #1;
        checks++; if (out_bus.aw_id !== 2'd0 || in_bus.aw_ready !== 1'b1) begin errors++; $display("FAIL mid_new got id=%0h r=%0h exp 0 1", out_bus.aw_id, in_bus.aw_ready); end
        tick();
        in_bus.aw_valid = 1'b0;
        out_bus.b_valid = 1'b1; out_bus.b_id = 2'd0;
        #1;
        checks++; if (in_bus.b_id !== 12'h3FF) begin errors++; $display("FAIL mid_b_id got %0h exp 3ff", in_bus.b_id); end
        tick();
        out_bus.b_valid = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_max_outstanding();
        test_slots_full();
        test_read_burst();
        test_read_with_write_full();
        test_reset_mid();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
